// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared framing definitions for the serial command link
package serial_pkg;

    typedef enum logic [2:0] {
        S_SYNC,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_HOLD
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Byte offsets within a frame; checksum follows the payload.
    localparam int FIELD_SYNC     = 0;
    localparam int FIELD_CMD      = 1;
    localparam int FIELD_LEN      = 2;
    localparam int FIELD_PAYLOAD  = 3;
    localparam int FRAME_OVERHEAD = 4;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/serial_payload_buffer.sv
// rtl/serial_payload_buffer.sv - simple dual-port payload RAM, registered read
module serial_payload_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_Clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // No reset on the array or read port so the RAM maps onto block memory.
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/serial_cmd_parser.sv
// rtl/serial_cmd_parser.sv - frames UART bytes into checksummed command packets
module serial_cmd_parser
    import serial_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 48000000,
    parameter int BAUDRATE        = 115200,
    parameter int MAX_PAYLOAD     = 16,
    parameter int TIMEOUT_BYTES   = 4
) (
    input  logic                             i_Clock,
    input  logic                             i_Reset,
    input  logic                             i_Rx_DV,
    input  logic [7:0]                       i_Rx_Byte,
    output logic                             o_Cmd_Valid,
    input  logic                             i_Cmd_Ack,
    output logic [7:0]                       o_Cmd,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0] o_Len,
    input  logic [$clog2(MAX_PAYLOAD)-1:0]   i_Rd_Addr,
    output logic [7:0]                       o_Rd_Data,
    output logic                             o_Busy,
    output logic                             o_Err_Checksum,
    output logic                             o_Err_Length,
    output logic                             o_Err_Timeout,
    output logic                             o_Err_Overrun
);

    localparam int CLKS_PER_BIT   = CLOCK_FREQUENCY / BAUDRATE;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW             = $clog2(MAX_PAYLOAD + 1);
    localparam int AW             = $clog2(MAX_PAYLOAD);
    localparam logic [7:0] MAX_LEN_BYTE = 8'(MAX_PAYLOAD);

    state_t          state;
    logic [7:0]      cmd_q;
    logic [7:0]      sum_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   idx_q;
    logic [TW-1:0]   timer_q;
    logic            timer_active;
    logic            timeout_hit;
    logic            wr_en;
    logic            unused_idx;

    assign timer_active = (state != S_SYNC) && (state != S_HOLD);
    assign timeout_hit  = timer_active && !i_Rx_DV && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign wr_en        = (state == S_PAYLOAD) && i_Rx_DV;
    assign unused_idx   = ^idx_q;

    // Gap timer: any strobe restarts it, and it idles at zero outside a partial frame.
    always_ff @(posedge i_Clock) begin
        if (i_Reset || !timer_active || i_Rx_DV || timeout_hit) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state          <= S_SYNC;
            cmd_q          <= '0;
            sum_q          <= '0;
            len_q          <= '0;
            idx_q          <= '0;
            o_Cmd_Valid    <= 1'b0;
            o_Cmd          <= '0;
            o_Len          <= '0;
            o_Busy         <= 1'b0;
            o_Err_Checksum <= 1'b0;
            o_Err_Length   <= 1'b0;
            o_Err_Timeout  <= 1'b0;
            o_Err_Overrun  <= 1'b0;
        end else begin
            o_Err_Checksum <= 1'b0;
            o_Err_Length   <= 1'b0;
            o_Err_Timeout  <= 1'b0;
            o_Err_Overrun  <= 1'b0;
            if (timeout_hit) begin
                state         <= S_SYNC;
                o_Busy        <= 1'b0;
                o_Err_Timeout <= 1'b1;
            end else if (state == S_HOLD && i_Cmd_Ack) begin
                // Release and hunt in the same cycle so a coincident sync byte is not lost.
                o_Cmd_Valid <= 1'b0;
                if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                    state  <= S_CMD;
                    o_Busy <= 1'b1;
                end else begin
                    state  <= S_SYNC;
                    o_Busy <= 1'b0;
                end
            end else if (i_Rx_DV) begin
                case (state)
                    S_SYNC: begin
                        if (i_Rx_Byte == SYNC_BYTE) begin
                            state  <= S_CMD;
                            o_Busy <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        cmd_q <= i_Rx_Byte;
                        sum_q <= i_Rx_Byte;
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        sum_q <= csum_add(sum_q, i_Rx_Byte);
                        len_q <= i_Rx_Byte[LW-1:0];
                        idx_q <= '0;
                        if (i_Rx_Byte > MAX_LEN_BYTE) begin
                            state        <= S_SYNC;
                            o_Busy       <= 1'b0;
                            o_Err_Length <= 1'b1;
                        end else if (i_Rx_Byte == 8'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        sum_q <= csum_add(sum_q, i_Rx_Byte);
                        idx_q <= idx_q + LW'(1);
                        if (idx_q == len_q - LW'(1)) begin
                            state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (i_Rx_Byte == sum_q) begin
                            state       <= S_HOLD;
                            o_Cmd_Valid <= 1'b1;
                            o_Cmd       <= cmd_q;
                            o_Len       <= len_q;
                        end else begin
                            state          <= S_SYNC;
                            o_Busy         <= 1'b0;
                            o_Err_Checksum <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        o_Err_Overrun <= 1'b1;
                    end
                    default: begin
                        state  <= S_SYNC;
                        o_Busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    serial_payload_buffer #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_payload_buffer (
        .i_Clock (i_Clock),
        .wr_en   (wr_en),
        .wr_addr (idx_q[AW-1:0]),
        .wr_data (i_Rx_Byte),
        .rd_addr (i_Rd_Addr),
        .rd_data (o_Rd_Data)
    );

endmodule
